// File: rtl/bloon_bg_fetch.sv
// Background fetch stage: VGA pixel coordinates -> background ROM address, palette index realigned
// with delayed coordinates/video-enable. Optional horizontal scroll: define BLOON_BG_SCROLL_EN.
module bloon_bg_fetch #(
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int ROM_LAT     = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              vde,
`ifdef BLOON_BG_SCROLL_EN
    input  logic [8:0]        scroll_x,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index_out,
    output logic [9:0]        out_X,
    output logic [9:0]        out_Y,
    output logic              out_vde
);
    typedef enum logic [1:0] {UNLOCKED, ACTIVE, VBLANK} state_t;

    localparam logic [9:0]        SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [9:0]        CX_LIM   = 10'(IMG_W);
    localparam logic [9:0]        RY_LIM   = 10'(IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    // Single conditional subtract; inputs are always below 2*IMG_W.
    function automatic logic [9:0] wrap_col(input logic [9:0] c);
        return (c >= CX_LIM) ? c - CX_LIM : c;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] rom_addr_q, addr_d;
    logic              vde_prev_q;
    logic              frame_start, line_end, oob, lock;
    logic [9:0]        cx, ry, col, scroll_eff;

    logic [9:0]                x_p0_q, y_p0_q;
    logic                      vld_p0_q, oob_p0_q, lk_p0_q;
    logic [ROM_LAT-1:0][9:0]   x_p1_q, y_p1_q;
    logic [ROM_LAT-1:0]        vld_p1_q, oob_p1_q, lk_p1_q;
    logic [3:0]                index_q;
    logic [9:0]                out_x_q, out_y_q;
    logic                      out_vde_q;

`ifdef BLOON_BG_SCROLL_EN
    logic [9:0] scroll_lat_q, scroll_red;

    assign scroll_red = wrap_col({1'b0, scroll_x});
    // The frame-start pixel already uses the value being latched.
    assign scroll_eff = frame_start ? scroll_red : scroll_lat_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            scroll_lat_q <= '0;
        else if (frame_start)
            scroll_lat_q <= scroll_red;
    end
`else
    assign scroll_eff = '0;
`endif

    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign cx          = DrawX >> SCALE_SHIFT;
    assign ry          = DrawY >> SCALE_SHIFT;
    assign oob         = (cx >= CX_LIM) || (ry >= RY_LIM);
    assign col         = wrap_col(cx + scroll_eff);
    assign line_end    = vde_prev_q && !vde && ((DrawY & SUB_MASK) == SUB_MASK);

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        addr_d     = rom_addr_q;
        lock       = 1'b1;
        if (frame_start) begin
            state_d    = ACTIVE;
            row_base_d = '0;
            addr_d     = oob ? '0 : ADDR_W'(col);
        end else begin
            case (state_q)
                UNLOCKED: begin
                    lock   = 1'b0;
                    addr_d = '0;
                end
                ACTIVE: begin
                    addr_d = oob ? '0 : row_base_q + ADDR_W'(col);
                    if (ry >= RY_LIM)
                        state_d = VBLANK;
                    else if (line_end)
                        row_base_d = row_base_q + ROW_STEP;
                end
                VBLANK: ;
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= UNLOCKED;
            row_base_q <= '0;
            vde_prev_q <= 1'b0;
            rom_addr_q <= '0;
            x_p0_q     <= '0;
            y_p0_q     <= '0;
            vld_p0_q   <= 1'b0;
            oob_p0_q   <= 1'b0;
            lk_p0_q    <= 1'b0;
            x_p1_q     <= '0;
            y_p1_q     <= '0;
            vld_p1_q   <= '0;
            oob_p1_q   <= '0;
            lk_p1_q    <= '0;
            index_q    <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_vde_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            vde_prev_q <= vde;
            // p0: address issue
            rom_addr_q <= addr_d;
            x_p0_q     <= DrawX;
            y_p0_q     <= DrawY;
            vld_p0_q   <= vde & lock;
            oob_p0_q   <= oob;
            lk_p0_q    <= lock;
            // p1: wait out the ROM read latency
            x_p1_q[0]   <= x_p0_q;
            y_p1_q[0]   <= y_p0_q;
            vld_p1_q[0] <= vld_p0_q;
            oob_p1_q[0] <= oob_p0_q;
            lk_p1_q[0]  <= lk_p0_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                x_p1_q[i]   <= x_p1_q[i-1];
                y_p1_q[i]   <= y_p1_q[i-1];
                vld_p1_q[i] <= vld_p1_q[i-1];
                oob_p1_q[i] <= oob_p1_q[i-1];
                lk_p1_q[i]  <= lk_p1_q[i-1];
            end
            // p2: output register, fill index for unlocked or out-of-image pixels
            index_q   <= (lk_p1_q[ROM_LAT-1] && !oob_p1_q[ROM_LAT-1]) ? rom_data : 4'd0;
            out_x_q   <= x_p1_q[ROM_LAT-1];
            out_y_q   <= y_p1_q[ROM_LAT-1];
            out_vde_q <= vld_p1_q[ROM_LAT-1];
        end
    end

    assign rom_addr  = rom_addr_q;
    assign index_out = index_q;
    assign out_X     = out_x_q;
    assign out_Y     = out_y_q;
    assign out_vde   = out_vde_q;
endmodule

// File: tb/tb_bloon_bg_fetch.sv
// Bench for bloon_bg_fetch: three instances (ROM_LAT=1, ROM_LAT=3, IMG_W=300) share one stimulus,
// each with its own ROM returning addr[3:0].
module tb_bloon_bg_fetch;
    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       vde;
`ifdef BLOON_BG_SCROLL_EN
    logic [8:0] scroll_x;
`endif
    logic [16:0] addr1, addr3, addrw;
    logic [3:0]  data1, data3, dataw, idx1, idx3, idxw;
    logic [3:0]  pipe3 [2];
    logic [9:0]  ox1, oy1, ox3, oy3, oxw, oyw;
    logic        ov1, ov3, ovw;

    int   vectors = 0;
    int   errors  = 0;
    int   n       = 0;
    logic locked  = 1'b0;
    logic [9:0] hx [1024];
    logic [9:0] hy [1024];
    logic       hv [1024];
    logic       hl [1024];

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        data1    <= addr1[3:0];
        dataw    <= addrw[3:0];
        pipe3[0] <= addr3[3:0];
        pipe3[1] <= pipe3[0];
        data3    <= pipe3[1];
    end

    bloon_bg_fetch #(.ROM_LAT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .vde(vde),
`ifdef BLOON_BG_SCROLL_EN
        .scroll_x(scroll_x),
`endif
        .rom_addr(addr1), .rom_data(data1), .index_out(idx1), .out_X(ox1), .out_Y(oy1), .out_vde(ov1));

    bloon_bg_fetch #(.ROM_LAT(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .vde(vde),
`ifdef BLOON_BG_SCROLL_EN
        .scroll_x(scroll_x),
`endif
        .rom_addr(addr3), .rom_data(data3), .index_out(idx3), .out_X(ox3), .out_Y(oy3), .out_vde(ov3));

    bloon_bg_fetch #(.IMG_W(300), .ROM_LAT(1)) dutw (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .vde(vde),
`ifdef BLOON_BG_SCROLL_EN
        .scroll_x(scroll_x),
`endif
        .rom_addr(addrw), .rom_data(dataw), .index_out(idxw), .out_X(oxw), .out_Y(oyw), .out_vde(ovw));

    function automatic int exp_addr(input logic [9:0] x, input logic [9:0] y, input int w);
        int cx, ry;
        cx = int'(x >> 1);
        ry = int'(y >> 1);
        if (cx >= w || ry >= 240) return 0;
        return ry * w + cx;
    endfunction

    function automatic logic [3:0] exp_idx(input logic [9:0] x, input logic [9:0] y, input int w);
        int a;
        a = exp_addr(x, y, w);
        return a[3:0];
    endfunction

    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic v);
        DrawX = x;
        DrawY = y;
        vde   = v;
        if (x == 10'd0 && y == 10'd0) locked = 1'b1;
        if (Reset) locked = 1'b0;
        @(posedge Clk);
        #1;
        hx[n] = x;
        hy[n] = y;
        hv[n] = v;
        hl[n] = locked;
        n++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) step(10'd5, 10'd3, 1'b1);
        vectors++; if (addr1 !== 17'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr1); end
        vectors++; if (idx1 !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx1); end
        vectors++; if (ox1 !== 10'd0 || oy1 !== 10'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", ox1, oy1); end
        vectors++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_vde got %0d want 0", ov1); end
        vectors++; if (addr3 !== 17'd0 || idx3 !== 4'd0 || ov3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got %0d/%0d/%0d want 0", addr3, idx3, ov3); end
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(10'd5, 10'd3, 1'b1);
            vectors++; if (ov1 !== 1'b0 || ov3 !== 1'b0) begin errors++; $display("FAIL unlocked_vde cyc %0d got %0d/%0d want 0", i, ov1, ov3); end
            vectors++; if (idx1 !== 4'd0 || idx3 !== 4'd0) begin errors++; $display("FAIL unlocked_idx cyc %0d got %0d/%0d want 0", i, idx1, idx3); end
        end
    endtask

    task automatic test_scan();
        int start, s7, k;
        logic [9:0] xs;
        start = n;
        s7    = -100;
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x <= 16; x++) begin
                xs = (x == 16) ? 10'd640 : 10'(x);
                step(xs, 10'(y), x != 16);
                if (xs == 10'd7 && y == 5) s7 = n - 1;
                vectors++; if (addr1 !== 17'(exp_addr(xs, 10'(y), 320))) begin errors++; $display("FAIL scan_addr1 (%0d,%0d) got %0d want %0d", xs, y, addr1, exp_addr(xs, 10'(y), 320)); end
                vectors++; if (addr3 !== 17'(exp_addr(xs, 10'(y), 320))) begin errors++; $display("FAIL scan_addr3 (%0d,%0d) got %0d want %0d", xs, y, addr3, exp_addr(xs, 10'(y), 320)); end
                vectors++; if (addrw !== 17'(exp_addr(xs, 10'(y), 300))) begin errors++; $display("FAIL scan_addrw (%0d,%0d) got %0d want %0d", xs, y, addrw, exp_addr(xs, 10'(y), 300)); end
                k = n - 3;
                if (k >= start) begin
                    vectors++; if (idx1 !== exp_idx(hx[k], hy[k], 320)) begin errors++; $display("FAIL scan_idx1 (%0d,%0d) got %0d want %0d", hx[k], hy[k], idx1, exp_idx(hx[k], hy[k], 320)); end
                    vectors++; if (idxw !== exp_idx(hx[k], hy[k], 300)) begin errors++; $display("FAIL scan_idxw (%0d,%0d) got %0d want %0d", hx[k], hy[k], idxw, exp_idx(hx[k], hy[k], 300)); end
                    vectors++; if (ox1 !== hx[k] || oy1 !== hy[k] || oxw !== hx[k] || oyw !== hy[k]) begin errors++; $display("FAIL scan_xy1 got %0d,%0d want %0d,%0d", ox1, oy1, hx[k], hy[k]); end
                    vectors++; if (ov1 !== hv[k] || ovw !== hv[k]) begin errors++; $display("FAIL scan_vde1 got %0d/%0d want %0d", ov1, ovw, hv[k]); end
                end
                k = n - 5;
                if (k >= start) begin
                    vectors++; if (idx3 !== exp_idx(hx[k], hy[k], 320)) begin errors++; $display("FAIL scan_idx3 (%0d,%0d) got %0d want %0d", hx[k], hy[k], idx3, exp_idx(hx[k], hy[k], 320)); end
                    vectors++; if (ox3 !== hx[k] || oy3 !== hy[k]) begin errors++; $display("FAIL scan_xy3 got %0d,%0d want %0d,%0d", ox3, oy3, hx[k], hy[k]); end
                    vectors++; if (ov3 !== hv[k]) begin errors++; $display("FAIL scan_vde3 got %0d want %0d", ov3, hv[k]); end
                end
                if (n - 1 == s7) begin
                    vectors++; if (addr1 !== 17'd643) begin errors++; $display("FAIL px75_addr got %0d want 643", addr1); end
                end
                if (n - 1 == s7 + 2) begin
                    vectors++; if (idx1 !== 4'd3 || ox1 !== 10'd7 || oy1 !== 10'd5 || ov1 !== 1'b1) begin errors++; $display("FAIL px75_lat3 got idx %0d xy %0d,%0d vde %0d want 3 7,5 1", idx1, ox1, oy1, ov1); end
                end
                if (n - 1 == s7 + 4) begin
                    vectors++; if (idx3 !== 4'd3 || ox3 !== 10'd7 || oy3 !== 10'd5 || ov3 !== 1'b1) begin errors++; $display("FAIL px75_lat5 got idx %0d xy %0d,%0d vde %0d want 3 7,5 1", idx3, ox3, oy3, ov3); end
                end
            end
        end
    endtask

    task automatic test_oob();
        int start, k, ew, e1;
        logic [9:0] xs;
        start = n;
        for (int i = 592; i <= 642; i++) begin
            xs = (i >= 640) ? 10'd640 : 10'(i);
            step(xs, 10'd6, i < 640);
            ew = (i < 600) ? 900 + i / 2 : 0;
            e1 = (i < 640) ? 960 + i / 2 : 0;
            vectors++; if (addrw !== 17'(ew)) begin errors++; $display("FAIL oob_addrw x=%0d got %0d want %0d", i, addrw, ew); end
            vectors++; if (addr1 !== 17'(e1)) begin errors++; $display("FAIL oob_addr1 x=%0d got %0d want %0d", i, addr1, e1); end
            k = n - 3;
            if (k >= start) begin
                ew = (hx[k] < 10'd600) ? 900 + int'(hx[k]) / 2 : 0;
                e1 = (hx[k] < 10'd640) ? 960 + int'(hx[k]) / 2 : 0;
                vectors++; if (idxw !== ew[3:0]) begin errors++; $display("FAIL oob_idxw x=%0d got %0d want %0d", hx[k], idxw, ew[3:0]); end
                vectors++; if (idx1 !== e1[3:0]) begin errors++; $display("FAIL oob_idx1 x=%0d got %0d want %0d", hx[k], idx1, e1[3:0]); end
            end
        end
    endtask

    task automatic test_resync();
        step(10'd0, 10'd0, 1'b1);
        vectors++; if (addr1 !== 17'd0) begin errors++; $display("FAIL resync_fs_addr got %0d want 0", addr1); end
        step(10'd8, 10'd1, 1'b1);
        vectors++; if (addr1 !== 17'd4 || addrw !== 17'd4) begin errors++; $display("FAIL resync_addr got %0d/%0d want 4", addr1, addrw); end
        step(10'd640, 10'd1, 1'b0);
        step(10'd640, 10'd1, 1'b0);
        vectors++; if (idx1 !== 4'd4 || ox1 !== 10'd8 || oy1 !== 10'd1) begin errors++; $display("FAIL resync_idx got %0d (%0d,%0d) want 4 (8,1)", idx1, ox1, oy1); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] fx [8];
        logic       fv [8];
        int         ea [8];
        fx = '{10'd0, 10'd2, 10'd4, 10'd6, 10'd8, 10'd640, 10'd640, 10'd640};
        fv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ea = '{0, 1, 2, 3, 4, 0, 0, 0};
        step(10'd10, 10'd200, 1'b1);
        step(10'd11, 10'd200, 1'b1);
        Reset = 1'b1;
        step(10'd12, 10'd200, 1'b1);
        Reset = 1'b0;
        vectors++; if (addr1 !== 17'd0 || addr3 !== 17'd0) begin errors++; $display("FAIL midrst_addr got %0d/%0d want 0", addr1, addr3); end
        vectors++; if (idx1 !== 4'd0 || idx3 !== 4'd0) begin errors++; $display("FAIL midrst_idx got %0d/%0d want 0", idx1, idx3); end
        vectors++; if (ox1 !== 10'd0 || oy1 !== 10'd0 || ox3 !== 10'd0) begin errors++; $display("FAIL midrst_xy got %0d,%0d want 0,0", ox1, oy1); end
        vectors++; if (ov1 !== 1'b0 || ov3 !== 1'b0) begin errors++; $display("FAIL midrst_vde got %0d/%0d want 0", ov1, ov3); end
        for (int i = 0; i < 8; i++) begin
            step(10'(13 + i), 10'd200, 1'b1);
            vectors++; if (ov1 !== 1'b0 || ov3 !== 1'b0 || idx1 !== 4'd0 || idx3 !== 4'd0) begin errors++; $display("FAIL midrst_blank cyc %0d got vde %0d/%0d idx %0d/%0d want 0", i, ov1, ov3, idx1, idx3); end
        end
        for (int i = 0; i < 8; i++) begin
            step(fx[i], 10'd0, fv[i]);
            vectors++; if (addr1 !== 17'(ea[i])) begin errors++; $display("FAIL resume_addr step %0d got %0d want %0d", i, addr1, ea[i]); end
            if (i >= 2) begin
                vectors++; if (idx1 !== 4'(ea[i-2]) || ov1 !== fv[i-2]) begin errors++; $display("FAIL resume_out1 step %0d got %0d/%0d want %0d/%0d", i, idx1, ov1, ea[i-2], fv[i-2]); end
            end
            if (i >= 4) begin
                vectors++; if (idx3 !== 4'(ea[i-4]) || ov3 !== fv[i-4]) begin errors++; $display("FAIL resume_out3 step %0d got %0d/%0d want %0d/%0d", i, idx3, ov3, ea[i-4], fv[i-4]); end
            end
        end
    endtask

`ifdef BLOON_BG_SCROLL_EN
    task automatic test_scroll();
        scroll_x = 9'd319;
        step(10'd0, 10'd0, 1'b1);
        vectors++; if (addr1 !== 17'd319) begin errors++; $display("FAIL scroll_fs got %0d want 319", addr1); end
        step(10'd2, 10'd0, 1'b1);
        vectors++; if (addr1 !== 17'd0 || addr3 !== 17'd0) begin errors++; $display("FAIL scroll_wrap got %0d/%0d want 0", addr1, addr3); end
        scroll_x = 9'd0;
        step(10'd4, 10'd0, 1'b1);
        vectors++; if (addr1 !== 17'd1) begin errors++; $display("FAIL scroll_midframe got %0d want 1", addr1); end
        step(10'd640, 10'd0, 1'b0);
        step(10'd0, 10'd0, 1'b1);
        step(10'd4, 10'd0, 1'b1);
        vectors++; if (addr1 !== 17'd2) begin errors++; $display("FAIL scroll_newframe got %0d want 2", addr1); end
    endtask
`endif

    initial begin
        Reset = 1'b1;
        DrawX = 10'd5;
        DrawY = 10'd3;
        vde   = 1'b1;
`ifdef BLOON_BG_SCROLL_EN
        scroll_x = 9'd0;
`endif
        test_reset();
        test_scan();
        test_oob();
        test_resync();
        test_reset_midframe();
`ifdef BLOON_BG_SCROLL_EN
        test_scroll();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
